// File: rtl/layer_mac_engine.sv
// layer_mac_engine
// Forward-pass compute stage for one Forward-Forward layer.
// It walks the weight memory and the input-activation buffer, accumulates one
// Q16.16 dot product per neuron, then saturates and optionally applies ReLU.
// Results leave one neuron at a time over a valid/ready handshake.
module layer_mac_engine #(
    parameter int NUM_NEURONS = 256,
    parameter int INPUT_SIZE  = 784,
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16,
    parameter int RELU_EN     = 1,
    parameter int DEPTH       = NUM_NEURONS * INPUT_SIZE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           en_a,
    output logic [$clog2(DEPTH)-1:0]       addr_a,
    input  logic [DATA_WIDTH-1:0]          rdata_a,
    output logic                           in_en,
    output logic [$clog2(INPUT_SIZE)-1:0]  in_addr,
    input  logic [DATA_WIDTH-1:0]          in_rdata,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(NUM_NEURONS)-1:0] out_neuron,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_sat
);

    localparam int AW        = $clog2(DEPTH);
    localparam int KW        = $clog2(INPUT_SIZE);
    localparam int NW        = $clog2(NUM_NEURONS);
    localparam int PROD_W    = 2 * DATA_WIDTH;
    localparam int TERM_W    = PROD_W - FRAC_BITS;
    localparam int ACC_WIDTH = 2 * DATA_WIDTH - FRAC_BITS + $clog2(INPUT_SIZE);

    localparam logic [KW-1:0] LAST_K = KW'(INPUT_SIZE - 1);
    localparam logic [NW-1:0] LAST_N = NW'(NUM_NEURONS - 1);

    // Representable range of a signed DATA_WIDTH result, widened to the accumulator
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = (ACC_WIDTH'(1) <<< (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -(ACC_WIDTH'(1) <<< (DATA_WIDTH - 1));

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FIN,
        ST_OUT
    } state_t;

    state_t                        state;
    logic [NW-1:0]                 neuron;
    logic                          drain_cnt;

    logic                          rd_valid;
    logic                          prod_valid;
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_WIDTH-1:0]   acc;

    logic                          acc_clear;
    logic signed [TERM_W-1:0]      term;
    logic [DATA_WIDTH-1:0]         fin_data;
    logic                          fin_sat;

    // Accumulator restarts whenever a new neuron begins: at pass start or after a handshake
    always_comb begin
        acc_clear = 1'b0;
        if (state == ST_IDLE && start) begin
            acc_clear = 1'b1;
        end else if (state == ST_OUT && out_ready) begin
            acc_clear = 1'b1;
        end
    end

    // Rescale the registered product back to Q16.16; >>> floors toward -inf
    always_comb begin
        term = TERM_W'(prod >>> FRAC_BITS);
    end

    // Clamp the accumulator to the output word, flag clamping, then apply optional ReLU
    always_comb begin
        fin_data = acc[DATA_WIDTH-1:0];
        fin_sat  = 1'b0;
        if (acc > SAT_MAX) begin
            fin_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            fin_sat  = 1'b1;
        end else if (acc < SAT_MIN) begin
            fin_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            fin_sat  = 1'b1;
        end
        if (RELU_EN != 0 && fin_data[DATA_WIDTH-1]) begin
            fin_data = '0;
        end
    end

    // Multiply-accumulate pipeline: read data lands one cycle after issue, product is
    // registered, and it is added on the following cycle only if its valid bit made it through
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid   <= 1'b0;
            prod_valid <= 1'b0;
            prod       <= '0;
            acc        <= '0;
        end else begin
            rd_valid   <= en_a && in_en;
            prod_valid <= rd_valid;
            if (rd_valid) begin
                prod <= PROD_W'($signed(rdata_a)) * PROD_W'($signed(in_rdata));
            end
            if (acc_clear) begin
                acc <= '0;
            end else if (prod_valid) begin
                acc <= acc + ACC_WIDTH'(term);
            end
        end
    end

    // Sequencer: issues the reads for each neuron, waits for the pipeline to empty,
    // latches the finished result and holds it until downstream takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            en_a       <= 1'b0;
            in_en      <= 1'b0;
            addr_a     <= '0;
            in_addr    <= '0;
            out_valid  <= 1'b0;
            out_neuron <= '0;
            out_data   <= '0;
            out_sat    <= 1'b0;
            neuron     <= '0;
            drain_cnt  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                        en_a    <= 1'b1;
                        in_en   <= 1'b1;
                        addr_a  <= '0;
                        in_addr <= '0;
                        neuron  <= '0;
                    end
                end
                ST_RUN: begin
                    // Weight address runs contiguously across neurons, so it never rewinds
                    addr_a <= addr_a + AW'(1);
                    if (in_addr == LAST_K) begin
                        in_addr   <= '0;
                        en_a      <= 1'b0;
                        in_en     <= 1'b0;
                        drain_cnt <= 1'b0;
                        state     <= ST_DRAIN;
                    end else begin
                        in_addr <= in_addr + KW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt) begin
                        state <= ST_FIN;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                ST_FIN: begin
                    out_data   <= fin_data;
                    out_sat    <= fin_sat;
                    out_neuron <= neuron;
                    out_valid  <= 1'b1;
                    state      <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (neuron == LAST_N) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            neuron <= neuron + NW'(1);
                            state  <= ST_RUN;
                            en_a   <= 1'b1;
                            in_en  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_mac_engine.sv
// Testbench for layer_mac_engine: two instances (ReLU off / on) share memories
// and handshake inputs; results are compared against table constants and a
// dot-product reference model computed with plain integer arithmetic.
module tb_layer_mac_engine;

    localparam int NN    = 2;
    localparam int IS    = 4;
    localparam int DW    = 32;
    localparam int FB    = 16;
    localparam int DEPTH = NN * IS;
    localparam int AW    = $clog2(DEPTH);
    localparam int KW    = $clog2(IS);
    localparam int NW    = $clog2(NN);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          out_ready;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] in_rdata;

    logic          busy_n, done_n, en_a_n, in_en_n, out_valid_n, out_sat_n;
    logic [AW-1:0] addr_a_n;
    logic [KW-1:0] in_addr_n;
    logic [NW-1:0] out_neuron_n;
    logic [DW-1:0] out_data_n;

    logic          busy_r, done_r, en_a_r, in_en_r, out_valid_r, out_sat_r;
    logic [AW-1:0] addr_a_r;
    logic [KW-1:0] in_addr_r;
    logic [NW-1:0] out_neuron_r;
    logic [DW-1:0] out_data_r;

    logic [DW-1:0] wmem [DEPTH];
    logic [DW-1:0] imem [IS];

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    logic [DW-1:0] res_data_n [NN];
    logic [DW-1:0] res_data_r [NN];
    logic          res_sat_n  [NN];
    logic          res_sat_r  [NN];
    int            res_count;

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] w;
        logic [DW-1:0] exp_n;
        logic [DW-1:0] exp_r;
        logic          exp_sat;
    } vec_t;

    vec_t vecs [4];

    layer_mac_engine #(
        .NUM_NEURONS(NN), .INPUT_SIZE(IS), .DATA_WIDTH(DW), .FRAC_BITS(FB),
        .RELU_EN(0), .DEPTH(DEPTH)
    ) dut_n (
        .clk(clk), .rst(rst), .start(start), .busy(busy_n), .done(done_n),
        .en_a(en_a_n), .addr_a(addr_a_n), .rdata_a(rdata_a),
        .in_en(in_en_n), .in_addr(in_addr_n), .in_rdata(in_rdata),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_neuron(out_neuron_n),
        .out_data(out_data_n), .out_sat(out_sat_n)
    );

    layer_mac_engine #(
        .NUM_NEURONS(NN), .INPUT_SIZE(IS), .DATA_WIDTH(DW), .FRAC_BITS(FB),
        .RELU_EN(1), .DEPTH(DEPTH)
    ) dut_r (
        .clk(clk), .rst(rst), .start(start), .busy(busy_r), .done(done_r),
        .en_a(en_a_r), .addr_a(addr_a_r), .rdata_a(rdata_a),
        .in_en(in_en_r), .in_addr(in_addr_r), .in_rdata(in_rdata),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_neuron(out_neuron_r),
        .out_data(out_data_r), .out_sat(out_sat_r)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // One-cycle-latency models of the weight memory and input buffer
    always @(posedge clk) begin
        if (en_a_n) rdata_a <= wmem[addr_a_n];
        if (in_en_n) in_rdata <= imem[in_addr_n];
    end

    // Count cycles in which done is high
    always @(posedge clk) begin
        if (done_n) done_cnt <= done_cnt + 1;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic fill_uniform(input logic [DW-1:0] x, input logic [DW-1:0] w);
        for (int k = 0; k < IS; k++) imem[k] = x;
        for (int a = 0; a < DEPTH; a++) wmem[a] = w;
    endtask

    function automatic logic [DW-1:0] rand_word();
        int v;
        if ($urandom_range(0, 3) == 0) begin
            return $urandom;
        end
        v = int'($urandom_range(0, 1048575)) - 524288;
        return v;
    endfunction

    // Reference: Q16.16 dot product with floor rescaling, then clamp and optional ReLU
    function automatic logic [DW:0] ref_result(input int n, input bit relu);
        longint sum;
        longint p;
        logic [DW-1:0] data;
        logic sat;
        sum = 0;
        for (int k = 0; k < IS; k++) begin
            p = longint'($signed(wmem[n*IS + k])) * longint'($signed(imem[k]));
            sum = sum + (p >>> FB);
        end
        sat = 1'b0;
        if (sum > 64'sd2147483647) begin
            data = 32'h7FFF_FFFF;
            sat = 1'b1;
        end else if (sum < -64'sd2147483648) begin
            data = 32'h8000_0000;
            sat = 1'b1;
        end else begin
            data = sum[DW-1:0];
        end
        if (relu && data[DW-1]) data = '0;
        return {sat, data};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy_n, 0);
        check({tag, "_done"}, done_n, 0);
        check({tag, "_en_a"}, en_a_n, 0);
        check({tag, "_in_en"}, in_en_n, 0);
        check({tag, "_addr_a"}, addr_a_n, 0);
        check({tag, "_in_addr"}, in_addr_n, 0);
        check({tag, "_out_valid"}, out_valid_n, 0);
        check({tag, "_out_neuron"}, out_neuron_n, 0);
        check({tag, "_out_data"}, out_data_n, 0);
        check({tag, "_out_sat"}, out_sat_n, 0);
        check({tag, "_out_data_relu"}, out_data_r, 0);
    endtask

    // Run one full pass with out_ready held high and collect every result
    task automatic apply_stimulus(input string tag);
        int budget;
        int done_before;
        done_before = done_cnt;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        res_count = 0;
        budget = 0;
        while (res_count < NN && budget < 20 * NN * (IS + 4)) begin
            if (out_valid_n) begin
                check($sformatf("%s_out_neuron%0d", tag, res_count), out_neuron_n, res_count);
                res_data_n[res_count] = out_data_n;
                res_data_r[res_count] = out_data_r;
                res_sat_n[res_count]  = out_sat_n;
                res_sat_r[res_count]  = out_sat_r;
                res_count++;
            end
            @(negedge clk);
            budget++;
        end
        check({tag, "_result_count"}, res_count, NN);
        check({tag, "_done_pulse"}, done_n, 1);
        check({tag, "_busy_low_at_done"}, busy_n, 0);
        @(negedge clk);
        check({tag, "_done_once"}, done_cnt - done_before, 1);
    endtask

    task automatic check_output(input string tag, input int n,
                                input logic [DW-1:0] exp_n, input logic exp_sat_n,
                                input logic [DW-1:0] exp_r, input logic exp_sat_r);
        check($sformatf("%s_n%0d_data", tag, n), res_data_n[n], exp_n);
        check($sformatf("%s_n%0d_sat", tag, n), res_sat_n[n], exp_sat_n);
        check($sformatf("%s_n%0d_data_relu", tag, n), res_data_r[n], exp_r);
        check($sformatf("%s_n%0d_sat_relu", tag, n), res_sat_r[n], exp_sat_r);
    endtask

    initial begin
        logic [DW:0] ref_n;
        logic [DW:0] ref_r;
        logic [DW-1:0] held_data;
        logic [NW-1:0] held_neuron;
        int budget;
        int done_before;
        bit exp_en;

        vecs[0] = '{x: 32'h0001_0000, w: 32'h0000_8000, exp_n: 32'h0002_0000, exp_r: 32'h0002_0000, exp_sat: 1'b0};
        vecs[1] = '{x: 32'h0001_0000, w: 32'hFFFF_0000, exp_n: 32'hFFFC_0000, exp_r: 32'h0000_0000, exp_sat: 1'b0};
        vecs[2] = '{x: 32'h7FFF_0000, w: 32'h7FFF_0000, exp_n: 32'h7FFF_FFFF, exp_r: 32'h7FFF_FFFF, exp_sat: 1'b1};
        vecs[3] = '{x: 32'h7FFF_0000, w: 32'h8000_0000, exp_n: 32'h8000_0000, exp_r: 32'h0000_0000, exp_sat: 1'b1};

        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        fill_uniform(vecs[0].x, vecs[0].w);
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Cycle-accurate read sequence; start held for 3 cycles to show it is ignored once running
        $display("[TB] address sequence");
        out_ready = 1'b1;
        start = 1'b1;
        check("idle_busy", busy_n, 0);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 3) start = 1'b0;
            exp_en = (c >= 1 && c <= 4) || (c >= 9 && c <= 12);
            check($sformatf("c%0d_en_a", c), en_a_n, exp_en);
            check($sformatf("c%0d_in_en", c), in_en_n, exp_en);
            if (exp_en) begin
                check($sformatf("c%0d_addr_a", c), addr_a_n, (c <= 4) ? c - 1 : c - 5);
                check($sformatf("c%0d_in_addr", c), in_addr_n, (c <= 4) ? c - 1 : c - 9);
            end
            check($sformatf("c%0d_out_valid", c), out_valid_n, (c == 8 || c == 16));
            check($sformatf("c%0d_done", c), done_n, (c == 17));
            check($sformatf("c%0d_busy", c), busy_n, (c <= 16));
            if (c == 8 || c == 16) begin
                check($sformatf("c%0d_out_neuron", c), out_neuron_n, (c == 8) ? 0 : 1);
                check($sformatf("c%0d_out_data", c), out_data_n, 32'h0002_0000);
            end
        end

        // Table-driven uniform vectors
        for (int v = 0; v < 4; v++) begin
            $display("[TB] table vector %0d", v);
            fill_uniform(vecs[v].x, vecs[v].w);
            apply_stimulus($sformatf("vec%0d", v));
            for (int n = 0; n < NN; n++) begin
                check_output($sformatf("vec%0d", v), n, vecs[v].exp_n, vecs[v].exp_sat,
                             vecs[v].exp_r, vecs[v].exp_sat);
            end
        end

        // Backpressure: result must hold and no reads may issue while out_ready is low
        $display("[TB] backpressure");
        fill_uniform(vecs[0].x, vecs[0].w);
        out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (!out_valid_n && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("bp_valid_seen", out_valid_n, 1);
        held_data = out_data_n;
        held_neuron = out_neuron_n;
        check("bp_first_data", held_data, 32'h0002_0000);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp%0d_valid", i), out_valid_n, 1);
            check($sformatf("bp%0d_data", i), out_data_n, held_data);
            check($sformatf("bp%0d_neuron", i), out_neuron_n, 0);
            check($sformatf("bp%0d_en_a", i), en_a_n, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_en_a", en_a_n, 1);
        check("bp_resume_addr_a", addr_a_n, 4);
        check("bp_resume_valid_low", out_valid_n, 0);
        budget = 0;
        while (busy_n && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("bp_pass_ends", busy_n, 0);
        @(negedge clk);

        // Reset asserted for one cycle in the middle of neuron 1
        $display("[TB] reset mid-run");
        out_ready = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        check("rst_pre_en_a", en_a_n, 1);
        check("rst_pre_addr_a", addr_a_n, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("midrst");
        done_before = done_cnt;
        repeat (30) @(negedge clk);
        check("midrst_no_done", done_cnt - done_before, 0);
        check("midrst_stays_idle", busy_n, 0);

        // Randomized passes against the reference model
        for (int r = 0; r < 8; r++) begin
            $display("[TB] random pass %0d", r);
            for (int k = 0; k < IS; k++) imem[k] = rand_word();
            for (int a = 0; a < DEPTH; a++) wmem[a] = rand_word();
            apply_stimulus($sformatf("rnd%0d", r));
            for (int n = 0; n < NN; n++) begin
                ref_n = ref_result(n, 1'b0);
                ref_r = ref_result(n, 1'b1);
                check_output($sformatf("rnd%0d", r), n, ref_n[DW-1:0], ref_n[DW],
                             ref_r[DW-1:0], ref_r[DW]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_mac_engine.md
# layer_mac_engine

Forward-pass compute stage for one Forward-Forward layer. Sequences reads from the layer's weight memory (read port, 1-cycle latency) and from the layer's input-activation buffer, accumulates one Q16.16 dot product per neuron, and emits saturated, optionally ReLU'd activations one neuron at a time over a valid/ready handshake to the downstream goodness/activation stage.

## Interface
- NUM_NEURONS, 256, neurons in the layer
- INPUT_SIZE, 784, inputs per neuron
- DATA_WIDTH, 32, Q16.16 word width
- FRAC_BITS, 16, fractional bits
- RELU_EN, 1, 1 = clamp negative results to 0
- DEPTH, NUM_NEURONS*INPUT_SIZE, weight memory depth
- ACC_WIDTH (local), 2*DATA_WIDTH-FRAC_BITS+$clog2(INPUT_SIZE), accumulator width
- One clock; reset is synchronous and active-high.
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a layer pass; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last neuron's handshake
- en_a  out  1  weight read enable
- addr_a  out  $clog2(DEPTH)  weight address, neuron*INPUT_SIZE + k
- rdata_a  in  DATA_WIDTH  weight data, valid 1 cycle after en_a
- in_en  out  1  input buffer read enable
- in_addr  out  $clog2(INPUT_SIZE)  input index k
- in_rdata  in  DATA_WIDTH  input data, valid 1 cycle after in_en
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_neuron  out  $clog2(NUM_NEURONS)  neuron index of out_data
- out_data  out  DATA_WIDTH  Q16.16 activation
- out_sat  out  1  result was saturated

## Operation
- States: IDLE, RUN, DRAIN, FIN, OUT.
- IDLE: start=1 -> RUN, neuron=0, weight address counter=0, accumulator cleared. start in any other state ignored.
- RUN: exactly INPUT_SIZE cycles; each cycle en_a=in_en=1, in_addr=k, addr_a=running counter (incremented by 1, no multiplier; contiguous across neurons). After k=INPUT_SIZE-1 -> DRAIN.
- Pipeline: cycle t issue; t+1 data arrives, signed 64-bit product registered; t+2 product >>> FRAC_BITS (arithmetic, truncation toward -inf) sign-extended and added to accumulator. Valid bits travel with the pipeline; only valid terms accumulate.
- DRAIN: 2 cycles, en_a=in_en=0 -> FIN.
- FIN: saturate accumulator to signed 32-bit (above 0x7FFFFFFF -> 0x7FFFFFFF; below 0x80000000 -> 0x80000000, out_sat=1), then if RELU_EN and negative -> 0; register into out_data/out_sat, out_neuron=neuron -> OUT.
- OUT: out_valid=1, out_data/out_neuron/out_sat stable until out_valid&&out_ready. On handshake: neuron<NUM_NEURONS-1 -> neuron+1, clear accumulator, RUN; else -> IDLE with done=1 in the following cycle.
- No reads issued in DRAIN, FIN, OUT, IDLE.

## Timing
- Reset values: busy=0, done=0, en_a=0, in_en=0, addr_a=0, in_addr=0, out_valid=0, out_neuron=0, out_data=0, out_sat=0; state IDLE, pipeline valids cleared.
- Reset mid-operation: abort immediately; partial results discarded; no done.
- start high in cycle 0 (IDLE) -> first en_a in cycle 1.
- Per neuron with out_ready held high: INPUT_SIZE (RUN) + 2 (DRAIN) + 1 (FIN) + 1 (OUT) = INPUT_SIZE+4 cycles; next neuron's first read in the cycle after handshake.
- Full pass, out_ready high: NUM_NEURONS*(INPUT_SIZE+4) cycles from first en_a to done pulse inclusive-minus-one; done in the cycle after last handshake, busy low in that same cycle.
- Accumulator never wraps: ACC_WIDTH covers the worst case INPUT_SIZE products.
- Weights written on the plasticity port during a pass are not this block's concern; a read returns whatever the memory holds.

## Test plan
- NUM_NEURONS=2, INPUT_SIZE=4, inputs 0x00010000, weights 0x00008000 -> two results 0x00020000, out_neuron 0 then 1, out_sat=0, done pulse once.
- Same, weights 0xFFFF0000 (-1.0): RELU_EN=1 -> out_data 0x00000000; RELU_EN=0 -> 0xFFFC0000; out_sat=0 both.
- Inputs and weights 0x7FFF0000 -> out_data 0x7FFFFFFF, out_sat=1; inputs 0x7FFF0000, weights 0x80000000, RELU_EN=0 -> 0x80000000, out_sat=1.
- Address check: start in cycle 0 -> addr_a 0,1,2,3 in cycles 1-4, in_addr 0-3; en_a low cycles 5-7; after handshake in cycle 8, addr_a 4-7 in cycles 9-12.
- Backpressure: out_ready low 10 cycles in OUT -> out_valid stays 1, out_data/out_neuron constant, en_a stays 0; raise out_ready -> next neuron RUN the cycle after.
- Assert rst for one cycle mid-RUN of neuron 1 -> all outputs reset values next cycle, no done; new start gives correct results from neuron 0.
